// File: rtl/rank_loader.sv
// rank_loader: collects (index, rank) beats into the sorter's flattened array,
// pulses sort_start for two cycles per frame, then stalls input until sort_done.
`default_nettype none
`timescale 1ns/1ps

module rank_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 32,
  parameter int IDX_WIDTH  = 5
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [IDX_WIDTH-1:0]             in_index,
  input  logic [DATA_WIDTH-1:0]            in_rank,
  input  logic                             in_last,
  output logic [DATA_WIDTH*NUM_WORDS-1:0]  array_out_flattened,
  output logic                             sort_start,
  input  logic                             sort_done,
  output logic                             busy,
  output logic [IDX_WIDTH:0]               word_count,
  output logic                             dup_err,
  output logic                             range_err,
  output logic [15:0]                      frame_count
);

  localparam logic [IDX_WIDTH:0] NUM_W = (IDX_WIDTH+1)'(NUM_WORDS);

  typedef enum logic [1:0] {
    COLLECT   = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_SORT = 2'd2
  } state_t;

  state_t                 state, state_next;
  logic                   launch_cnt;
  logic [NUM_WORDS-1:0]   written;
  logic [NUM_WORDS-1:0]   sel;
  logic                   accept, in_range, slot_used, do_write, new_slot;
  logic                   frame_end, clear;
  logic [IDX_WIDTH:0]     wc_after;

  // Beat decode: one-hot slot select is empty for out-of-range indices.
  always_comb begin
    sel = '0;
    for (int j = 0; j < NUM_WORDS; j++)
      sel[j] = in_range && (in_index == IDX_WIDTH'(j));
  end

  assign accept    = in_valid & in_ready;
  assign in_range  = ({1'b0, in_index} < NUM_W);
  assign slot_used = |(sel & written);
  assign do_write  = accept & in_range;
  assign new_slot  = do_write & ~slot_used;
  assign wc_after  = word_count + {{IDX_WIDTH{1'b0}}, new_slot};
  assign frame_end = accept & (in_last | (wc_after == NUM_W));
  assign clear     = (state == WAIT_SORT) & sort_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= COLLECT;
      launch_cnt <= 1'b0;
    end else begin
      state      <= state_next;
      launch_cnt <= (state == LAUNCH) ? ~launch_cnt : 1'b0;
    end
  end

  // Outputs decode from the registered state only, so sort_start falls with reset.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    sort_start = 1'b0;
    busy       = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        if (frame_end) state_next = LAUNCH;
      end
      LAUNCH: begin
        sort_start = 1'b1;
        busy       = 1'b1;
        if (launch_cnt) state_next = WAIT_SORT;
      end
      WAIT_SORT: begin
        busy = 1'b1;
        if (sort_done) state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      array_out_flattened <= '0;
      written             <= '0;
      word_count          <= '0;
      dup_err             <= 1'b0;
      range_err           <= 1'b0;
      frame_count         <= 16'd0;
    end else if (clear) begin
      array_out_flattened <= '0;
      written             <= '0;
      word_count          <= '0;
      dup_err             <= 1'b0;
      range_err           <= 1'b0;
      frame_count         <= frame_count + 16'd1;
    end else if (accept) begin
      for (int j = 0; j < NUM_WORDS; j++)
        if (sel[j]) array_out_flattened[j*DATA_WIDTH +: DATA_WIDTH] <= in_rank;
      written    <= written | sel;
      word_count <= wc_after;
      if (do_write && slot_used) dup_err <= 1'b1;
      if (!in_range) range_err <= 1'b1;
    end
  end

endmodule

`default_nettype wire
